// File: rtl/vga_frame_monitor.sv
// Receiver-side VGA monitor: rebuilds pixel coordinates from sampled syncs, checks
// line/frame lengths and black blanking, and signs every frame with a rotate-xor.
module vga_frame_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        pixel_tick,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        in_active,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic        frame_valid,
  output logic        timing_error,
  output logic        blank_error
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int CW      = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_LO       = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]    H_HI       = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]    V_LO       = 10'(V_SYNC + V_BACK - 1);
  localparam logic [9:0]    V_HI       = 10'(V_SYNC + V_BACK - 1 + V_ACTIVE);
  localparam logic [9:0]    CNT_MAX    = 10'h3FF;
  localparam logic [CW-1:0] CLEAN_LAST = CW'(LOCK_FRAMES - 1);

  // state  | meaning
  // SEARCH | no timing reference yet; waiting for the first applied frame restart
  // ALIGN  | counting consecutive clean frames;  LOCKED | checking, errors are sticky
  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_clean, w_clean_next;

  logic        r_hs_prev, r_vs_prev, r_v_pending, r_frame_terr, r_frame_ok;
  logic [9:0]  r_h_cnt, r_v_cnt, r_x_pos, r_y_pos;
  logic [15:0] r_acc, r_frame_crc;
  logic        r_in_active, r_locked, r_frame_done, r_frame_valid;
  logic        r_timing_error, r_blank_error;

  logic [11:0] w_rgb;
  logic        w_h_edge, w_v_edge, w_v_apply, w_active;
  logic        w_line_err, w_frame_err, w_terr, w_blank_err, w_restart;
  logic [9:0]  w_h_next, w_v_next;

  assign w_rgb     = {red, green, blue};
  assign w_h_edge  = pixel_tick & r_hs_prev & ~h_sync;
  assign w_v_edge  = pixel_tick & r_vs_prev & ~v_sync;
  assign w_v_apply = w_h_edge & r_v_pending;

  assign w_h_next = w_h_edge ? 10'd0 :
                    (r_h_cnt == CNT_MAX) ? r_h_cnt : r_h_cnt + 10'd1;
  assign w_v_next = w_v_apply ? 10'd0 :
                    (w_h_edge && (r_v_cnt != CNT_MAX)) ? r_v_cnt + 10'd1 : r_v_cnt;

  // activity is judged on the coordinates of the pixel being sampled now
  assign w_active = (w_h_next >= H_LO) && (w_h_next < H_HI) &&
                    (w_v_next >= V_LO) && (w_v_next < V_HI);

  assign w_line_err  = w_h_edge  && (r_state != SEARCH) && (r_h_cnt != H_LAST);
  assign w_frame_err = w_v_apply && (r_state != SEARCH) && (r_v_cnt != V_LAST);
  assign w_terr      = w_line_err | w_frame_err;
  assign w_blank_err = pixel_tick && (r_state == LOCKED) && !w_active && (w_rgb != 12'h000);
  assign w_restart   = w_v_apply && (r_state != SEARCH);

  always_comb begin
    w_state_next = r_state;
    w_clean_next = r_clean;
    case (r_state)
      SEARCH: begin
        if (w_v_apply) begin
          w_state_next = ALIGN;
          w_clean_next = '0;
        end
      end
      ALIGN: begin
        if (w_terr) begin
          w_clean_next = '0;
        end else if (w_v_apply) begin
          if (r_frame_terr) begin
            w_clean_next = '0;
          end else if (r_clean == CLEAN_LAST) begin
            w_state_next = LOCKED;
            w_clean_next = '0;
          end else begin
            w_clean_next = r_clean + CW'(1);
          end
        end
      end
      LOCKED: begin
        if (w_terr) begin
          w_state_next = SEARCH;
          w_clean_next = '0;
        end
      end
      default: begin
        w_state_next = SEARCH;
        w_clean_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state <= SEARCH;
      r_clean <= '0;
    end else begin
      r_state <= w_state_next;
      r_clean <= w_clean_next;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_hs_prev      <= 1'b1;
      r_vs_prev      <= 1'b1;
      r_v_pending    <= 1'b0;
      r_h_cnt        <= '0;
      r_v_cnt        <= '0;
      r_acc          <= 16'hFFFF;
      r_frame_terr   <= 1'b0;
      r_frame_ok     <= 1'b0;
      r_x_pos        <= '0;
      r_y_pos        <= '0;
      r_in_active    <= 1'b0;
      r_locked       <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_crc    <= '0;
      r_frame_valid  <= 1'b0;
      r_timing_error <= 1'b0;
      r_blank_error  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (pixel_tick) begin
        r_hs_prev   <= h_sync;
        r_vs_prev   <= v_sync;
        r_h_cnt     <= w_h_next;
        r_v_cnt     <= w_v_next;
        r_v_pending <= w_v_edge | (r_v_pending & ~w_h_edge);
        r_in_active <= w_active && (w_state_next != SEARCH);
        r_x_pos     <= w_active ? w_h_next - H_LO : 10'd0;
        r_y_pos     <= w_active ? w_v_next - V_LO : 10'd0;
        r_locked    <= (w_state_next == LOCKED);

        if (w_v_apply)
          r_acc <= 16'hFFFF;
        else if (w_active)
          r_acc <= {r_acc[14:0], r_acc[15]} ^ {4'h0, w_rgb};

        if (w_v_apply)
          r_frame_terr <= 1'b0;
        else if (w_terr)
          r_frame_terr <= 1'b1;

        if (w_restart) begin
          r_frame_done  <= 1'b1;
          r_frame_crc   <= r_acc;
          r_frame_valid <= r_frame_ok && (r_state == LOCKED) && !w_terr && !w_blank_err;
        end else if (w_terr && (r_state == LOCKED)) begin
          r_frame_valid <= 1'b0;
        end

        if (w_v_apply)
          r_frame_ok <= (w_state_next == LOCKED) && !w_blank_err;
        else if (w_terr || w_blank_err || (w_state_next != LOCKED))
          r_frame_ok <= 1'b0;

        if (w_terr && (r_state == LOCKED))
          r_timing_error <= 1'b1;
        if (w_blank_err)
          r_blank_error <= 1'b1;
      end
    end
  end

  assign x_pos        = r_x_pos;
  assign y_pos        = r_y_pos;
  assign in_active    = r_in_active;
  assign locked       = r_locked;
  assign frame_done   = r_frame_done;
  assign frame_crc    = r_frame_crc;
  assign frame_valid  = r_frame_valid;
  assign timing_error = r_timing_error;
  assign blank_error  = r_blank_error;
endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
Receiver end of the PPU's VGA output. It samples h_sync, v_sync and 12-bit RGB at pixel rate and recovers the pixel coordinates. It checks line and frame timing, checks that blanking is black, and produces a per-frame signature. It runs in-silicon as a self-check block and in benches as a synthesizable golden monitor, so benches do not need to log output for an external simulator.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, h_sync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, v_sync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-low reset
pixel_tick  in  1  one-clock strobe per pixel (every 4th clk at 25 MHz); all sampling is gated by it
h_sync  in  1  active-low horizontal sync
v_sync  in  1  active-low vertical sync
red, green, blue  in  4 each  pixel colour
x_pos  out  10  recovered column 0..639, valid when in_active
y_pos  out  10  recovered row 0..479, valid when in_active
in_active  out  1  current sample is inside the active area and the monitor is not in SEARCH
locked  out  1  monitor is in state LOCKED
frame_done  out  1  one-clk pulse at each frame restart
frame_crc  out  16  signature of the last completed frame
frame_valid  out  1  frame_crc comes from a frame captured while LOCKED with no errors
timing_error  out  1  sticky; a line or frame length mismatch occurred while LOCKED
blank_error  out  1  sticky; non-zero RGB occurred outside the active area while LOCKED

Behaviour:
- Reset (reset=0): all outputs 0. h_cnt=0, v_cnt=0, acc=16'hFFFF, sync history registers=1, v_pending=0, state=SEARCH.
- Nothing changes on clocks without pixel_tick. Outputs are registered; x_pos, y_pos and in_active lag the sampled pixel by 1 clk.
- H edge: h_sync was 1 on the previous tick and is 0 on this tick. On an H edge, h_cnt<=0. On other ticks, h_cnt<=h_cnt+1, saturating at 1023.
- V edge: v_sync falling, detected on any tick. It sets v_pending. The next H edge applies it: v_cnt<=0 and v_pending cleared. Other H edges do v_cnt<=v_cnt+1, saturating at 1023.
- Timing: the generator changes v_sync at line start (x=0).
- Active-area condition:
  - h_cnt in [H_SYNC+H_BACK, +H_ACTIVE), i.e. [144,783].
  - v_cnt in [V_SYNC+V_BACK-1, +V_ACTIVE), i.e. [34,513].
  - x_pos = h_cnt-144; y_pos = v_cnt-34.
- Line check: on every H edge outside SEARCH, the old h_cnt must equal H_TOTAL-1 (799).
- Frame check: on every applied V edge outside SEARCH, the old v_cnt must equal V_TOTAL-1 (524).
- States:
  - SEARCH: exits to ALIGN on the first applied V edge. No checks are made.
  - ALIGN: clean_frames counts frames with no line or frame error. An error resets the count to 0. Reaching LOCK_FRAMES moves to LOCKED.
  - LOCKED: any line or frame error sets timing_error and moves to SEARCH, with clean_frames=0.
- Signature: on each active-area tick, acc <= {acc[14:0],acc[15]} ^ {4'h0,red,green,blue}.
- Frame restart (each applied V edge, not in SEARCH):
  - frame_done pulses for 1 clk.
  - frame_crc<=acc; acc<=16'hFFFF.
  - frame_valid<= (state was LOCKED for the whole frame and no error occurred in it).
- Blank check: while LOCKED, any non-zero RGB on a non-active tick sets blank_error.
- Sticky flags clear only on reset.
- Simultaneous events:
  - H and V edge on the same tick: H processes first, then the V edge sets v_pending; it applies on the next H edge.
  - Error on the same tick as a V edge: the transition is to SEARCH, frame_done still pulses, and frame_valid=0.
- Saturated counters (lost sync) always give a length mismatch, which is an error.
- Reset mid-frame: the monitor returns immediately to the reset state and needs fresh lock.

Test Plan:
- Nominal 640x480 all-black PPU output for 3 frames -> locked=1 after the 2nd frame restart; 3rd-frame frame_crc=16'hFFFF, frame_valid=1, no errors.
- Single white pixel (12'hFFF) at (0,0), rest black -> frame_crc=16'h7800. in_active is first seen at h_cnt 144, v_cnt 34, with x_pos=0, y_pos=0.
- After lock, one line shortened to 799 pixels -> timing_error=1, locked=0, that frame's frame_valid=0. Re-lock occurs after 2 clean frames.
- After lock, RGB=12'h00F during the h front porch -> blank_error=1; locked stays 1; frame_crc still updates.
- reset=0 asserted mid-frame while locked -> all outputs 0 asynchronously; after release the monitor passes SEARCH -> ALIGN -> LOCKED across 1+2 frame restarts.
- pixel_tick held low for 1000 clks with sync toggling -> counters, state and outputs unchanged.
